uart_pattern_tx: RTL and testbench

Self-contained UART test-pattern transmitter for bring-up of frame format and baud rate on new boards. It contains a fractional-N bit-rate generator, a serializer with configurable data bits, parity and stop bits, and a character sequencer. The sequencer sends an incrementing or fixed character stream separated by a programmable idle gap. It drives the board TX pin directly and exposes status for LEDs.

---
 rtl/uart_pattern_tx.sv | 146 ++++++++++++++
 tb/tb_uart_pattern_tx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pattern_tx.sv
// uart_pattern_tx: UART test-pattern transmitter with fractional-N bit clock, serializer and character sequencer
//   clk         system clock
//   reset       synchronous reset, active-high
//   enable      1 = run the pattern, 0 = stop after the current frame
//   sertx       UART TX line, idle high
//   busy        1 while a frame or gap is in progress
//   frame_done  one-clk pulse when a frame's last stop bit ends
//   cur_char    character currently or most recently sent
//   frame_count frames completed, wraps at 16 bits
module uart_pattern_tx #(
    parameter int Width    = 15,
    parameter int Incr     = 314,
    parameter int DataBits = 8,
    parameter int Parity   = 0,
    parameter int StopBits = 1,
    parameter int First    = 97,
    parameter int Last     = 122,
    parameter int Mode     = 0,
    parameter int GapBits  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        sertx,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  cur_char,
    output logic [15:0] frame_count
);
    localparam int AccW = Width + 1;
    localparam logic [Width:0] IncrW = AccW'(Incr);
    localparam logic [7:0] Mask = 8'hFF >> (8 - DataBits);
    localparam logic [7:0] FirstC = 8'(First);
    localparam logic [7:0] LastC = 8'(Last);
    localparam logic [15:0] DataEnd = 16'(DataBits - 1);
    localparam logic [15:0] StopEnd = 16'(StopBits - 1);
    localparam logic [15:0] GapEnd = 16'(GapBits - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

    state_t state, state_n;
    logic [Width-1:0] acc;
    logic [Width:0] sum;
    logic tick;
    logic [7:0] shreg, shreg_n, char_n, load_c;
    logic [15:0] cnt, cnt_n, count_n;
    logic par, par_n, done_n, sertx_n, load;

    // bit tick is the carry out of the phase accumulator
    assign sum = {1'b0, acc} + IncrW;
    assign tick = sum[Width];

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n = cnt;
        char_n = cur_char;
        count_n = frame_count;
        done_n = 1'b0;
        load = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    state_n = enable ? START : IDLE;
                    load = enable;
                end
                START: begin
                    state_n = DATA;
                    cnt_n = '0;
                end
                DATA: begin
                    if (cnt == DataEnd) begin
                        state_n = (Parity != 0) ? PARITY : STOP;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + 16'd1;
                        shreg_n = shreg >> 1;
                    end
                end
                PARITY: begin
                    state_n = STOP;
                    cnt_n = '0;
                end
                STOP: begin
                    if (cnt == StopEnd) begin
                        done_n = 1'b1;
                        count_n = frame_count + 16'd1;
                        char_n = (Mode == 1 || cur_char == LastC) ? FirstC : cur_char + 8'd1;
                        cnt_n = '0;
                        state_n = !enable ? IDLE : (GapBits > 0) ? GAP : START;
                        load = enable && GapBits == 0;
                    end else begin
                        cnt_n = cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (!enable) begin
                        state_n = IDLE;
                    end else if (cnt == GapEnd) begin
                        state_n = START;
                        cnt_n = '0;
                        load = 1'b1;
                    end else begin
                        cnt_n = cnt + 16'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        // the frame's character is frozen into the shifter on entry to START,
        // using the already-advanced character for back-to-back frames
        load_c = char_n & Mask;
        par_n = load ? (^load_c) ^ (Parity == 2) : par;
        if (load) shreg_n = load_c;
        // line level is registered from the next state so the pin is glitch-free
        sertx_n = (state_n == START) ? 1'b0 :
                  (state_n == DATA) ? shreg_n[0] :
                  (state_n == PARITY) ? par_n : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            state <= IDLE;
            shreg <= '0;
            cnt <= '0;
            par <= 1'b0;
            sertx <= 1'b1;
            busy <= 1'b0;
            frame_done <= 1'b0;
            cur_char <= FirstC;
            frame_count <= '0;
        end else begin
            acc <= sum[Width-1:0];
            state <= state_n;
            shreg <= shreg_n;
            cnt <= cnt_n;
            par <= par_n;
            sertx <= sertx_n;
            busy <= state_n != IDLE;
            frame_done <= done_n;
            cur_char <= char_n;
            frame_count <= count_n;
        end
    end
endmodule

// File: tb/tb_uart_pattern_tx.sv
// tb_uart_pattern_tx: self-checking bench for uart_pattern_tx against a bit-list frame model
module tb_uart_pattern_tx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] en = 4'b0;
    logic [3:0] tx, bz, dn;
    logic [7:0] cc [4];
    logic [15:0] fc [4];
    int checks = 0;
    int errors = 0;
    logic smp[$];
    logic bsy[$];
    int dpos[$];
    logic eb[$];

    always #5 clk = ~clk;

    uart_pattern_tx #(.Width(4), .Incr(4), .GapBits(2)) d0 (
        .clk(clk), .reset(reset), .enable(en[0]), .sertx(tx[0]), .busy(bz[0]),
        .frame_done(dn[0]), .cur_char(cc[0]), .frame_count(fc[0]));
    uart_pattern_tx #(.Width(4), .Incr(4), .First(121), .Last(122), .GapBits(0)) d1 (
        .clk(clk), .reset(reset), .enable(en[1]), .sertx(tx[1]), .busy(bz[1]),
        .frame_done(dn[1]), .cur_char(cc[1]), .frame_count(fc[1]));
    uart_pattern_tx #(.Width(4), .Incr(4), .DataBits(7), .Parity(2), .StopBits(2), .GapBits(2)) d2 (
        .clk(clk), .reset(reset), .enable(en[2]), .sertx(tx[2]), .busy(bz[2]),
        .frame_done(dn[2]), .cur_char(cc[2]), .frame_count(fc[2]));
    uart_pattern_tx #(.Width(4), .Incr(4), .DataBits(7), .Parity(1), .StopBits(2), .Mode(1), .GapBits(2)) d3 (
        .clk(clk), .reset(reset), .enable(en[3]), .sertx(tx[3]), .busy(bz[3]),
        .frame_done(dn[3]), .cur_char(cc[3]), .frame_count(fc[3]));

    // expected line levels of one frame, one entry per bit time
    function automatic void add_frame(input int ch, input int db, input int par, input int sb);
        int ones = 0;
        eb.push_back(1'b0);
        for (int i = 0; i < db; i++) begin
            eb.push_back(logic'((ch >> i) & 1));
            ones += (ch >> i) & 1;
        end
        if (par != 0) eb.push_back(logic'((ones % 2) ^ (par == 2 ? 1 : 0)));
        repeat (sb) eb.push_back(1'b1);
    endfunction

    function automatic int next_char(input int ch, input int first, input int last, input int mode);
        return (mode == 1 || ch == last) ? first : ch + 1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        en = 4'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_start(input int idx, output int waited);
        waited = 0;
        while (tx[idx] !== 1'b0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic wait_idle(input int idx);
        int n = 0;
        while (bz[idx] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bz[idx] !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout dut%0d: busy=%b required 0", idx, bz[idx]);
        end
    endtask

    // sample cycle c is the c-th falling clock edge after the start edge
    task automatic record(input int idx, input int ncyc, input int drop_at);
        smp.delete();
        bsy.delete();
        dpos.delete();
        for (int c = 0; c < ncyc; c++) begin
            smp.push_back(tx[idx]);
            bsy.push_back(bz[idx]);
            if (dn[idx] === 1'b1) dpos.push_back(c);
            if (c == drop_at) en[idx] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            checks++;
            if (tx[0] !== 1'b1 || bz[0] !== 1'b0 || dn[0] !== 1'b0 || cc[0] !== 8'd97 || fc[0] !== 16'd0) begin
                errors++;
                bad++;
                if (bad < 4) $display("FAIL reset_idle c=%0d: tx=%b busy=%b done=%b char=%0d count=%0d required 1 0 0 97 0",
                                      c, tx[0], bz[0], dn[0], cc[0], fc[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        int w;
        logic bad;
        do_reset();
        en[0] = 1'b1;
        wait_start(0, w);
        checks++;
        if (w > 4) begin
            errors++;
            $display("FAIL basic_latency: %0d clk required <= 4", w);
        end
        record(0, 49, -1);
        eb.delete();
        add_frame(97, 8, 0, 1);
        for (int i = 0; i < 10; i++) begin
            bad = 1'b0;
            for (int k = 0; k < 4; k++) if (smp[4*i+k] !== eb[i]) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL basic_bit%0d: got %b required %b for 4 clk", i, smp[4*i+1], eb[i]);
            end
        end
        checks++;
        if (dpos.size() != 1 || dpos[0] != 40) begin
            errors++;
            $display("FAIL basic_done: %0d pulses first at %0d, required one at 40", dpos.size(), dpos.size() > 0 ? dpos[0] : -1);
        end
        checks++;
        if (fc[0] !== 16'd1 || cc[0] !== 8'd98) begin
            errors++;
            $display("FAIL basic_count: count=%0d char=%0d required 1 98", fc[0], cc[0]);
        end
        bad = 1'b0;
        for (int c = 40; c < 48; c++) if (smp[c] !== 1'b1 || bsy[c] !== 1'b1) bad = 1'b1;
        checks++;
        if (bad || smp[48] !== 1'b0) begin
            errors++;
            $display("FAIL basic_gap: gap idle/busy ok=%b next start=%b required 1 0", !bad, smp[48]);
        end
        en[0] = 1'b0;
        wait_idle(0);
    endtask

    task automatic test_wrap();
        int w;
        int ch = 121;
        logic bad;
        do_reset();
        en[1] = 1'b1;
        wait_start(1, w);
        record(1, 161, -1);
        eb.delete();
        for (int f = 0; f < 4; f++) begin
            add_frame(ch, 8, 0, 1);
            ch = next_char(ch, 121, 122, 0);
        end
        for (int f = 0; f < 4; f++) begin
            bad = 1'b0;
            for (int c = 40*f; c < 40*f + 40; c++) if (smp[c] !== eb[c/4]) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL wrap_frame%0d: line differs from character %0d frame", f, f % 2 == 0 ? 121 : 122);
            end
        end
        checks++;
        if (dpos.size() != 4 || dpos[0] != 40 || dpos[1] != 80 || dpos[2] != 120 || dpos[3] != 160) begin
            errors++;
            $display("FAIL wrap_done: %0d pulses, required 4 at 40/80/120/160", dpos.size());
        end
        checks++;
        if (fc[1] !== 16'd4 || cc[1] !== 8'(ch)) begin
            errors++;
            $display("FAIL wrap_count: count=%0d char=%0d required 4 %0d", fc[1], cc[1], ch);
        end
        en[1] = 1'b0;
        wait_idle(1);
    endtask

    task automatic test_format();
        int w;
        logic bad;
        for (int idx = 2; idx < 4; idx++) begin
            do_reset();
            en[idx] = 1'b1;
            wait_start(idx, w);
            en[idx] = 1'b0;
            record(idx, 60, -1);
            eb.delete();
            add_frame(8'h61, 7, idx == 2 ? 2 : 1, 2);
            bad = 1'b0;
            for (int c = 0; c < 44; c++) if (smp[c] !== eb[c/4]) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL format_frame dut%0d: line differs from 11-bit frame model", idx);
            end
            checks++;
            if (smp[33] !== (idx == 2 ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL format_parity dut%0d: got %b required %b", idx, smp[33], idx == 2 ? 1'b0 : 1'b1);
            end
            bad = 1'b0;
            for (int c = 44; c < 60; c++) if (smp[c] !== 1'b1 || bsy[c] !== 1'b0) bad = 1'b1;
            checks++;
            if (dpos.size() != 1 || dpos[0] != 44 || bad) begin
                errors++;
                $display("FAIL format_end dut%0d: %0d done pulses, idle after=%b, required one at 44 and idle", idx, dpos.size(), !bad);
            end
            checks++;
            if (cc[idx] !== (idx == 2 ? 8'd98 : 8'd97)) begin
                errors++;
                $display("FAIL format_char dut%0d: got %0d required %0d", idx, cc[idx], idx == 2 ? 98 : 97);
            end
        end
    endtask

    task automatic test_stop_mid();
        int w, b;
        logic bad;
        for (int it = 0; it < 3; it++) begin
            b = (it == 0) ? 3 : int'($urandom_range(0, 7));
            do_reset();
            en[0] = 1'b1;
            wait_start(0, w);
            record(0, 60, 4*(b+1) + int'($urandom_range(0, 3)));
            eb.delete();
            add_frame(97, 8, 0, 1);
            bad = 1'b0;
            for (int c = 0; c < 40; c++) if (smp[c] !== eb[c/4]) bad = 1'b1;
            for (int c = 40; c < 60; c++) if (smp[c] !== 1'b1 || bsy[c] !== 1'b0) bad = 1'b1;
            checks++;
            if (bad || dpos.size() != 1 || dpos[0] != 40) begin
                errors++;
                $display("FAIL stop_mid bit%0d: frame/idle ok=%b done pulses=%0d required complete frame, one pulse at 40, idle", b, !bad, dpos.size());
            end
            en[0] = 1'b1;
            wait_start(0, w);
            record(0, 41, 0);
            eb.delete();
            add_frame(next_char(97, 97, 122, 0), 8, 0, 1);
            bad = 1'b0;
            for (int c = 0; c < 40; c++) if (smp[c] !== eb[c/4]) bad = 1'b1;
            checks++;
            if (bad || w > 4 || fc[0] !== 16'd2 || cc[0] !== 8'd99) begin
                errors++;
                $display("FAIL stop_resume bit%0d: frame ok=%b latency=%0d count=%0d char=%0d required 1 <=4 2 99", b, !bad, w, fc[0], cc[0]);
            end
            wait_idle(0);
        end
    endtask

    task automatic test_reset_mid();
        int w, b;
        logic bad;
        for (int it = 0; it < 2; it++) begin
            b = (it == 0) ? 5 : int'($urandom_range(0, 7));
            do_reset();
            en[0] = 1'b1;
            wait_start(0, w);
            repeat (4*(b+1) + 1) @(negedge clk);
            reset = 1'b1;
            en[0] = 1'b0;
            @(negedge clk);
            checks++;
            if (tx[0] !== 1'b1 || bz[0] !== 1'b0 || cc[0] !== 8'd97 || fc[0] !== 16'd0 || dn[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid bit%0d: tx=%b busy=%b char=%0d count=%0d done=%b required 1 0 97 0 0", b, tx[0], bz[0], cc[0], fc[0], dn[0]);
            end
            reset = 1'b0;
            bad = 1'b0;
            for (int c = 0; c < 60; c++) begin
                if (dn[0] !== 1'b0 || tx[0] !== 1'b1) bad = 1'b1;
                @(negedge clk);
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL reset_mid_quiet bit%0d: frame_done or line activity after reset, required none", b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_format();
        test_stop_mid();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
